rom_stream_boot_loader: RTL and testbench



---
 rtl/rom_stream_boot_loader.sv | 200 ++++++++++++++++++++
 tb/tb_rom_stream_boot_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_boot_loader.sv
// Boot sequencer: streams WORD_COUNT words into the hack_soc ROM loader, then releases the CPU.
// Optional checksum verification is enabled by defining ROM_STREAM_BOOT_LOADER_CHECKSUM_EN.
module rom_stream_boot_loader #(
    parameter int DATA_WIDTH      = 16,
    parameter int WORD_COUNT      = 24,
    parameter int COUNT_WIDTH     = 16,
    parameter int SCK_HALF_CYCLES = 2,
    parameter int ACK_TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   src_valid,
    input  logic [DATA_WIDTH-1:0]  src_data,
    output logic                   src_ready,
    output logic                   rom_loader_load,
    output logic                   rom_loader_sck,
    output logic [DATA_WIDTH-1:0]  rom_loader_data,
    input  logic                   rom_loader_ack,
    output logic                   hack_external_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_loaded
`ifdef ROM_STREAM_BOOT_LOADER_CHECKSUM_EN
    ,
    input  logic [DATA_WIDTH-1:0]  expected_sum,
    output logic [DATA_WIDTH-1:0]  sum_out
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_WAIT_ACK_HI,
        S_WAIT_ACK_LO,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    // One counter serves both the sck timing and the ack timeout, so it spans the larger of the two.
    localparam int CYC_MAX = (ACK_TIMEOUT > SCK_HALF_CYCLES) ? ACK_TIMEOUT : SCK_HALF_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam logic [CYC_W-1:0]       HALF_LAST    = CYC_W'(SCK_HALF_CYCLES - 1);
    localparam logic [CYC_W-1:0]       TIMEOUT_LAST = CYC_W'(ACK_TIMEOUT - 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_WORD    = COUNT_WIDTH'(WORD_COUNT);

    state_t                 state;
    state_t                 next_state;
    logic [CYC_W-1:0]       cyc_cnt;
    logic [COUNT_WIDTH-1:0] words_next;
    logic                   boot_start;
    logic                   handshake;
    logic                   sck_min_met;
    logic                   cyc_timeout;
    logic                   checksum_ok;

    assign boot_start  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign handshake   = (state == S_FETCH) && src_valid;
    assign sck_min_met = (cyc_cnt >= HALF_LAST);
    assign cyc_timeout = (cyc_cnt == TIMEOUT_LAST);
    assign words_next  = words_loaded + COUNT_WIDTH'(1);

`ifdef ROM_STREAM_BOOT_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_reg;

    assign checksum_ok = (sum_reg == expected_sum);
    assign sum_out     = sum_reg;

    // Running modulo-2^DATA_WIDTH sum of every accepted word, restarted with each boot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg <= '0;
        end else if (boot_start) begin
            sum_reg <= '0;
        end else if (handshake) begin
            sum_reg <= sum_reg + src_data;
        end
    end
`else
    assign checksum_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (boot_start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (src_valid) begin
                    next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cyc_cnt == HALF_LAST) begin
                    next_state = S_WAIT_ACK_HI;
                end
            end
            S_WAIT_ACK_HI: begin
                if (rom_loader_ack && sck_min_met) begin
                    next_state = S_WAIT_ACK_LO;
                end else if (cyc_timeout) begin
                    next_state = S_ERROR;
                end
            end
            S_WAIT_ACK_LO: begin
                if (!rom_loader_ack) begin
                    next_state = (words_next == LAST_WORD) ? S_RELEASE : S_FETCH;
                end else if (cyc_timeout) begin
                    next_state = S_ERROR;
                end
            end
            S_RELEASE: begin
                next_state = checksum_ok ? S_DONE : S_ERROR;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // The cycle counter restarts on every state change, so each timed state measures from its own entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt <= '0;
        end else if (next_state != state) begin
            cyc_cnt <= '0;
        end else if ((state == S_SETUP) || (state == S_WAIT_ACK_HI) || (state == S_WAIT_ACK_LO)) begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            words_loaded    <= '0;
            rom_loader_data <= '0;
        end else begin
            if (boot_start) begin
                words_loaded <= '0;
            end else if ((state == S_WAIT_ACK_LO) && !rom_loader_ack) begin
                words_loaded <= words_next;
            end
            if (handshake) begin
                rom_loader_data <= src_data;
            end
        end
    end

    always_comb begin
        src_ready           = 1'b0;
        rom_loader_load     = 1'b0;
        rom_loader_sck      = 1'b0;
        hack_external_reset = 1'b1;
        busy                = 1'b0;
        done                = 1'b0;
        error               = 1'b0;
        case (state)
            S_FETCH: begin
                src_ready       = 1'b1;
                rom_loader_load = 1'b1;
                busy            = 1'b1;
            end
            S_SETUP, S_WAIT_ACK_LO: begin
                rom_loader_load = 1'b1;
                busy            = 1'b1;
            end
            S_WAIT_ACK_HI: begin
                rom_loader_load = 1'b1;
                rom_loader_sck  = 1'b1;
                busy            = 1'b1;
            end
            S_RELEASE: begin
                busy = 1'b1;
            end
            S_DONE: begin
                hack_external_reset = 1'b0;
                done                = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rom_stream_boot_loader.sv
// Directed bench for rom_stream_boot_loader: a default-width instance (short ack timeout) and a
// 32-bit single-word instance, each driven by a stream source and a same-clock SoC ack model.
module tb_rom_stream_boot_loader;

    localparam int AN = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    int compared   = 0;
    int mismatched = 0;

    // Instance A: defaults except a 16-cycle ack timeout
    logic        aResetN = 1'b0;
    logic        aStart  = 1'b0;
    logic        aSrcValid = 1'b0;
    logic [15:0] aSrcData  = '0;
    logic        aSrcReady, aLoad, aSck, aHackReset, aBusy, aDone, aError;
    logic [15:0] aRomData, aWords;
    logic        aAck = 1'b0;

    // Instance B: 32-bit, one word, wide sck
    logic        bResetN = 1'b0;
    logic        bStart  = 1'b0;
    logic        bSrcValid = 1'b0;
    logic [31:0] bSrcData  = 32'hDEADBEEF;
    logic        bSrcReady, bLoad, bSck, bHackReset, bBusy, bDone, bError;
    logic [31:0] bRomData;
    logic [15:0] bWords;
    logic        bAck = 1'b0;

`ifdef ROM_STREAM_BOOT_LOADER_CHECKSUM_EN
    logic [15:0] aExpSum = 16'd276;
    logic [15:0] aSumOut;
    logic [31:0] bExpSum = 32'hDEADBEEF;
    logic [31:0] bSumOut;
`endif

    rom_stream_boot_loader #(
        .DATA_WIDTH(16), .WORD_COUNT(AN), .COUNT_WIDTH(16), .SCK_HALF_CYCLES(2), .ACK_TIMEOUT(16)
    ) dutA (
        .clk(clk), .reset_n(aResetN), .start(aStart),
        .src_valid(aSrcValid), .src_data(aSrcData), .src_ready(aSrcReady),
        .rom_loader_load(aLoad), .rom_loader_sck(aSck), .rom_loader_data(aRomData),
        .rom_loader_ack(aAck), .hack_external_reset(aHackReset),
        .busy(aBusy), .done(aDone), .error(aError), .words_loaded(aWords)
`ifdef ROM_STREAM_BOOT_LOADER_CHECKSUM_EN
        , .expected_sum(aExpSum), .sum_out(aSumOut)
`endif
    );

    rom_stream_boot_loader #(
        .DATA_WIDTH(32), .WORD_COUNT(1), .COUNT_WIDTH(16), .SCK_HALF_CYCLES(4), .ACK_TIMEOUT(1024)
    ) dutB (
        .clk(clk), .reset_n(bResetN), .start(bStart),
        .src_valid(bSrcValid), .src_data(bSrcData), .src_ready(bSrcReady),
        .rom_loader_load(bLoad), .rom_loader_sck(bSck), .rom_loader_data(bRomData),
        .rom_loader_ack(bAck), .hack_external_reset(bHackReset),
        .busy(bBusy), .done(bDone), .error(bError), .words_loaded(bWords)
`ifdef ROM_STREAM_BOOT_LOADER_CHECKSUM_EN
        , .expected_sum(bExpSum), .sum_out(bSumOut)
`endif
    );

    // Test knobs, written only by the stimulus side; aEpoch tells the model a new boot began.
    int          aEpoch    = 0;
    bit          aRandom   = 1'b0;
    int          aStuckIdx = -1;
    logic [15:0] aOffset   = '0;

    // Model state, written only by the model process
    int          aSeenEpoch = 0;
    int          aIdx = AN;
    bit          aHsPending = 1'b0;
    int          aCapCount = 0;
    logic [15:0] aCap [0:63];
    int          aRise [0:63];
    int          aViol = 0;
    int          aRun = 0;
    int          aLastRun = 0;
    bit          aSckDly = 1'b0;
    bit          aSckPrev = 1'b0;
    bit          aLoadPrev = 1'b0;
    bit          aHackPrev = 1'b1;
    int          aLoadFall = 0;
    int          aHackFall = 0;

    // Source and SoC model for A, evaluated mid-cycle so the DUT samples settled values on posedge.
    always @(negedge clk) begin
        if (aEpoch != aSeenEpoch) begin
            aSeenEpoch = aEpoch;
            aIdx       = 0;
            aHsPending = 1'b0;
            aCapCount  = 0;
            aViol      = 0;
        end
        if (aHsPending) aIdx++;
        aSrcValid  = (aIdx < AN) && (!aRandom || ($urandom_range(0, 9) < 3));
        aSrcData   = 16'(aIdx) + aOffset;
        aHsPending = aSrcValid && aSrcReady;

        if (aSck && !aSckPrev && aCapCount < 64) begin
            aCap[aCapCount]  = aRomData;
            aRise[aCapCount] = cycle;
            aCapCount++;
        end
        if (aSck && aSrcReady) aViol++;
        if (aSck) begin
            aRun++;
        end else if (aSckPrev) begin
            aLastRun = aRun;
            aRun     = 0;
        end
        aAck     = (aStuckIdx == aCapCount - 1) ? 1'b0 : aSckDly;
        aSckDly  = aSck;
        aSckPrev = aSck;

        if (!aLoad && aLoadPrev) aLoadFall = cycle;
        if (!aHackReset && aHackPrev) aHackFall = cycle;
        aLoadPrev = aLoad;
        aHackPrev = aHackReset;
    end

    // Model for B: always-valid single word, 1-cycle ack delay
    int          bCapCount = 0;
    logic [31:0] bCap = '0;
    int          bRun = 0;
    bit          bSckDly = 1'b0;
    bit          bSckPrev = 1'b0;

    always @(negedge clk) begin
        bSrcValid = 1'b1;
        if (bSck && !bSckPrev) begin
            bCap = bRomData;
            bCapCount++;
        end
        if (bSck) bRun++;
        bAck     = bSckDly;
        bSckDly  = bSck;
        bSckPrev = bSck;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit randomValid, input int stuckIdx, input logic [15:0] offset);
        @(negedge clk); #1;
        aRandom   = randomValid;
        aStuckIdx = stuckIdx;
        aOffset   = offset;
        aEpoch++;
        aStart    = 1'b1;
        @(negedge clk); #1;
        aStart    = 1'b0;
    endtask

    task automatic waitA(input string tag, input int budget);
        int n;
        n = 0;
        while (!(aDone || aError) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (!(aDone || aError)) checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int bad;
        int n;

        $display("[TB] reset state");
        #1;
        checkOutput("rst src_ready", 32'(aSrcReady), 32'd0);
        checkOutput("rst load",      32'(aLoad),     32'd0);
        checkOutput("rst sck",       32'(aSck),      32'd0);
        checkOutput("rst data",      32'(aRomData),  32'd0);
        checkOutput("rst hack",      32'(aHackReset), 32'd1);
        checkOutput("rst busy",      32'(aBusy),     32'd0);
        checkOutput("rst done",      32'(aDone),     32'd0);
        checkOutput("rst error",     32'(aError),    32'd0);
        checkOutput("rst words",     32'(aWords),    32'd0);
        repeat (2) @(negedge clk);
        #1;
        aResetN = 1'b1;
        bResetN = 1'b1;

        $display("[TB] full boot, always-valid source");
        applyStimulus(1'b0, -1, 16'd0);
        checkOutput("boot busy", 32'(aBusy), 32'd1);
        checkOutput("boot hack", 32'(aHackReset), 32'd1);
        repeat (40) @(negedge clk);
        #1;
        aStart = 1'b1;
        @(negedge clk); #1;
        aStart = 1'b0;
        waitA("boot", 2000);
        checkOutput("boot count", 32'(aCapCount), 32'd24);
        for (int i = 0; i < AN; i++) checkOutput($sformatf("boot word%0d", i), 32'(aCap[i]), 32'(i));
        checkOutput("boot words_loaded", 32'(aWords), 32'd24);
        checkOutput("boot done",  32'(aDone),  32'd1);
        checkOutput("boot error", 32'(aError), 32'd0);
        checkOutput("boot busy end", 32'(aBusy), 32'd0);
        checkOutput("boot hack end", 32'(aHackReset), 32'd0);
        checkOutput("boot hack after load", 32'(aHackFall - aLoadFall), 32'd1);
        checkOutput("boot word period", 32'(aRise[2] - aRise[1]), 32'd7);

        $display("[TB] full boot, sparse source");
        applyStimulus(1'b1, -1, 16'd0);
        checkOutput("sparse done cleared", 32'(aDone), 32'd0);
        checkOutput("sparse hack raised",  32'(aHackReset), 32'd1);
        waitA("sparse", 4000);
        bad = 0;
        for (int i = 0; i < AN; i++) if (aCap[i] !== 16'(i)) bad++;
        checkOutput("sparse count", 32'(aCapCount), 32'd24);
        checkOutput("sparse bad words", 32'(bad), 32'd0);
        checkOutput("sparse error", 32'(aError), 32'd0);
        checkOutput("sparse sck while ready", 32'(aViol), 32'd0);
        checkOutput("sparse words_loaded", 32'(aWords), 32'd24);

        $display("[TB] ack stuck low on word 5");
        applyStimulus(1'b0, 5, 16'd0);
        waitA("stuck", 2000);
        checkOutput("stuck error", 32'(aError), 32'd1);
        checkOutput("stuck sck high cycles", 32'(aLastRun), 32'd16);
        checkOutput("stuck words_loaded", 32'(aWords), 32'd5);
        checkOutput("stuck load", 32'(aLoad), 32'd0);
        checkOutput("stuck sck",  32'(aSck),  32'd0);
        checkOutput("stuck busy", 32'(aBusy), 32'd0);
        checkOutput("stuck hack", 32'(aHackReset), 32'd1);
        applyStimulus(1'b0, -1, 16'd0);
        checkOutput("restart error cleared", 32'(aError), 32'd0);
        waitA("restart", 2000);
        checkOutput("restart done", 32'(aDone), 32'd1);
        checkOutput("restart error", 32'(aError), 32'd0);
        checkOutput("restart words_loaded", 32'(aWords), 32'd24);
        checkOutput("restart count", 32'(aCapCount), 32'd24);

        $display("[TB] reset during word 10");
        applyStimulus(1'b0, -1, 16'd0);
        n = 0;
        while (!(aCapCount == 11 && aSck) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("midreset reached sck", 32'(aSck), 32'd1);
        aResetN = 1'b0;
        #1;
        checkOutput("midreset sck",  32'(aSck),  32'd0);
        checkOutput("midreset load", 32'(aLoad), 32'd0);
        checkOutput("midreset busy", 32'(aBusy), 32'd0);
        checkOutput("midreset hack", 32'(aHackReset), 32'd1);
        checkOutput("midreset words", 32'(aWords), 32'd0);
        @(negedge clk); #1;
        aResetN = 1'b1;

`ifdef ROM_STREAM_BOOT_LOADER_CHECKSUM_EN
        $display("[TB] checksum");
        aExpSum = 16'd300;
        applyStimulus(1'b0, -1, 16'd1);
        waitA("sum ok", 2000);
        checkOutput("sum ok done", 32'(aDone), 32'd1);
        checkOutput("sum ok value", 32'(aSumOut), 32'd300);
        aExpSum = 16'd301;
        applyStimulus(1'b0, -1, 16'd1);
        waitA("sum bad", 2000);
        checkOutput("sum bad error", 32'(aError), 32'd1);
        checkOutput("sum bad hack",  32'(aHackReset), 32'd1);
        checkOutput("sum bad value", 32'(aSumOut), 32'd300);
`endif

        $display("[TB] 32-bit single word");
        @(negedge clk); #1;
        bStart = 1'b1;
        @(negedge clk); #1;
        bStart = 1'b0;
        n = 0;
        while (!(bDone || bError) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("wide done", 32'(bDone), 32'd1);
        checkOutput("wide count", 32'(bCapCount), 32'd1);
        checkOutput("wide data", bCap, 32'hDEADBEEF);
        checkOutput("wide sck min high", 32'(bRun >= 4), 32'd1);
        checkOutput("wide words_loaded", 32'(bWords), 32'd1);
        checkOutput("wide hack", 32'(bHackReset), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
